cls_decision_ctrl: RTL and testbench

Controller for the final classification stage. Accepts the fully-connected layer's class scores as a serial ready/valid stream, one frame of NUM_CLASSES scores at a time, and computes a running argmax. It presents one decision per frame on a ready/valid output with backpressure. Sits between the FC layer output and the digit display/host interface, and also supports frame abort and frame counting.

---
 rtl/cls_pkg.sv | 18 +
 rtl/cls_decision_ctrl_cond.sv | 25 ++
 rtl/cls_decision_ctrl.sv | 111 +++++++++++
 tb/tb_cls_decision_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cls_pkg.sv
// rtl/cls_pkg.sv - shared parameters, FSM state type and saturation constant for the classification stage
package cls_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 12;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 16;

    // Largest positive score; the magnitude of the most negative score saturates here
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/cls_decision_ctrl_cond.sv
// rtl/cls_decision_ctrl_cond.sv - cls_score_cond: score conditioning, saturating magnitude under CLS_ABS_SCORE_EN
module cls_score_cond #(
    parameter int W = 12
) (
    input  logic [W-1:0] raw,
    output logic [W-1:0] cond
);

`ifdef CLS_ABS_SCORE_EN
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] SAT_POS  = {1'b0, {(W-1){1'b1}}};

    always_comb begin
        cond = raw;
        if (raw == MOST_NEG) begin
            cond = SAT_POS;
        end else if (raw[W-1]) begin
            cond = -raw;
        end
    end
`else
    assign cond = raw;
`endif

endmodule

// File: rtl/cls_decision_ctrl.sv
// rtl/cls_decision_ctrl.sv - running-argmax decision controller over framed score stream; optional CLS_ABS_SCORE_EN
module cls_decision_ctrl #(
    parameter int NUM_CLASSES = cls_pkg::NUM_CLASSES,
    parameter int DATA_W      = cls_pkg::DATA_W,
    parameter int IDX_W       = cls_pkg::IDX_W,
    parameter int CNT_W       = cls_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [IDX_W-1:0]  d_class,
    output logic [DATA_W-1:0] d_score,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);
    import cls_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  best_idx;
    logic [DATA_W-1:0] best;
    logic [DATA_W-1:0] cond;
    logic              accept;
    logic              last;
    logic              handshake;

    cls_score_cond #(
        .W(DATA_W)
    ) u_cond (
        .raw  (s_data),
        .cond (cond)
    );

    assign last      = (idx == IDX_W'(NUM_CLASSES - 1));
    assign accept    = s_valid & s_ready;
    assign handshake = d_valid & d_ready & ~abort;
    assign d_class   = best_idx;
    assign d_score   = best;

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        d_valid    = 1'b0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
            end
            COLLECT: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            HOLD: begin
                busy    = 1'b1;
                d_valid = 1'b1;
            end
            default: ;
        endcase
        // abort wins over any score presented in the same cycle
        if (abort || !rst_n) begin
            s_ready = 1'b0;
        end
        case (state)
            IDLE:    if (s_valid && s_ready) state_next = COLLECT;
            COLLECT: if (s_valid && s_ready && last) state_next = HOLD;
            HOLD:    if (d_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            best      <= '0;
            best_idx  <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_next;
            if (abort) begin
                idx <= '0;
            end else if (accept) begin
                if (state == IDLE) begin
                    best     <= cond;
                    best_idx <= '0;
                    idx      <= IDX_W'(1);
                end else begin
                    // strict compare: ties keep the earlier class
                    if ($signed(cond) > $signed(best)) begin
                        best     <= cond;
                        best_idx <= idx;
                    end
                    idx <= last ? '0 : idx + 1'b1;
                end
            end
            if (handshake) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cls_decision_ctrl.sv
// tb/tb_cls_decision_ctrl.sv - scoreboard bench for cls_decision_ctrl
module tb_cls_decision_ctrl;
    import cls_pkg::*;

    typedef struct {
        logic [IDX_W-1:0]  cls;
        logic [DATA_W-1:0] score;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              abort;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              d_valid;
    logic              d_ready;
    logic [IDX_W-1:0]  d_class;
    logic [DATA_W-1:0] d_score;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic signed [DATA_W-1:0] fr [NUM_CLASSES];

    cls_decision_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_class   (d_class),
        .d_score   (d_score),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int cls, input int score);
        exp_t e;
        e.cls   = IDX_W'(cls);
        e.score = DATA_W'(score);
        sb.push_back(e);
    endtask

    // Monitor: every delivered decision is compared against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && d_valid && d_ready && !abort) begin
            if (sb.size() == 0) begin
                check("unexpected_decision", 32'(d_class), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("d_class", 32'(d_class), 32'(e.cls));
                check("d_score", 32'(d_score), 32'(e.score));
            end
        end
    end

    // Sends the first n entries of fr; called and returns at posedge+1
    task automatic send_frame(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int waited;
            s_valid = 1'b1;
            s_data  = fr[i];
            waited  = 0;
            @(negedge clk);
            while (!s_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            if (gap > 0 && i < n - 1) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        if (n == NUM_CLASSES) begin
            @(negedge clk);
            check("latency_d_valid", 32'(d_valid), 32'd1);
        end
    endtask

    task automatic finish_handshake(input int cnt);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("d_valid_drop", 32'(d_valid), 32'd0);
        check("frame_cnt", 32'(frame_cnt), 32'(cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_d_class", 32'(d_class), 32'd0);
        check("rst_d_score", 32'(d_score), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    endtask

    task automatic apply_reset();
        s_valid = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] h_score;
        logic [IDX_W-1:0]  h_class;
        rst_n   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        d_ready = 1'b1;
        @(posedge clk);
        apply_reset();

        fr = '{5, -3, 7, 2, 7, 0, 1, -8, 6, 4};
`ifdef CLS_ABS_SCORE_EN
        push_exp(7, 8);
`else
        push_exp(2, 7);
`endif
        send_frame(NUM_CLASSES, 0);
        finish_handshake(1);

        fr = '{-100, -100, -100, -100, -100, -100, -100, -100, -100, -100};
`ifdef CLS_ABS_SCORE_EN
        push_exp(0, 100);
`else
        push_exp(0, -100);
`endif
        send_frame(NUM_CLASSES, 0);
        finish_handshake(2);

        fr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        push_exp(9, 9);
        send_frame(NUM_CLASSES, 3);
        finish_handshake(3);

        // Backpressure: decision must hold steady for 20 cycles
        d_ready = 1'b0;
        fr = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        push_exp(5, 9);
        send_frame(NUM_CLASSES, 0);
        h_class = d_class;
        h_score = d_score;
        check("hold_class", 32'(h_class), 32'd5);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hold_d_valid", 32'(d_valid), 32'd1);
            check("hold_s_ready", 32'(s_ready), 32'd0);
            check("hold_d_class", 32'(d_class), 32'(h_class));
            check("hold_d_score", 32'(d_score), 32'(h_score));
        end
        @(posedge clk);
        #1;
        d_ready = 1'b1;
        finish_handshake(4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("frame_cnt_once", 32'(frame_cnt), 32'd4);
        @(posedge clk);
        #1;

        // Abort after the 4th score, then a clean frame
        fr = '{50, 60, 70, 80, 0, 0, 0, 0, 0, 0};
        send_frame(4, 0);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = DATA_W'(500);
        @(negedge clk);
        check("abort_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        abort   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        fr = '{1, 2, 3, 4, 5, 6, 40, 7, 8, 9};
        push_exp(6, 40);
        send_frame(NUM_CLASSES, 0);
        finish_handshake(5);

        // Abort in HOLD with d_ready=1: no delivery, no count
        d_ready = 1'b0;
        fr = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        send_frame(NUM_CLASSES, 0);
        @(posedge clk);
        #1;
        abort   = 1'b1;
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        abort   = 1'b0;
        d_ready = 1'b0;
        @(negedge clk);
        check("hold_abort_d_valid", 32'(d_valid), 32'd0);
        check("hold_abort_cnt", 32'(frame_cnt), 32'd5);
        @(posedge clk);
        #1;
        d_ready = 1'b1;

        // Reset mid-COLLECT, then a frame is decided correctly
        fr = '{11, 22, 33, 0, 0, 0, 0, 0, 0, 0};
        send_frame(3, 0);
        apply_reset();
        fr = '{-5, -4, -3, -2, -1, -6, -7, -8, -9, -10};
`ifdef CLS_ABS_SCORE_EN
        push_exp(9, 10);
`else
        push_exp(4, -1);
`endif
        send_frame(NUM_CLASSES, 0);
        finish_handshake(1);

        // Reset while a decision is pending
        d_ready = 1'b0;
        fr = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        send_frame(NUM_CLASSES, 0);
        apply_reset();
        d_ready = 1'b1;
        fr = '{-2048, 100, 50, -99, 0, 3, -5, 99, 10, -1};
`ifdef CLS_ABS_SCORE_EN
        push_exp(0, int'(MAX_POS));
`else
        push_exp(1, 100);
`endif
        send_frame(NUM_CLASSES, 0);
        finish_handshake(1);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
